vga_spi_line_fetch: RTL
=======================

Name: vga_spi_line_fetch

Overview:
Parametrised SPI flash line fetcher for the VGA demo path. On request it issues READ (03h) or FAST_READ (0Bh + dummy cycles) with a caller-supplied address, and streams BUFFER_BITS data bits into one half of a ping-pong buffer. The other half is presented bit-serially to the pixel pipeline. This lets the fetch of line N+1 overlap the display of line N, replacing the fixed stored/direct line split.

Parameters:
BUFFER_BITS, 128, data bits per fetch and per buffer half; must be a multiple of 8 and at least 8.
ADDR_WIDTH, 24, number of address bits sent after the command, MSB first.
DUMMY_CYCLES, 8, idle SCLK cycles inserted after the address when fast_read=1.

Ports:
clk  in  1  system clock; spi_sclk is ~clk.
reset  in  1  synchronous, active-low reset.
req  in  1  start fetch; sampled on rising clk; accepted only when busy=0.
req_addr  in  ADDR_WIDTH  flash address, captured on acceptance.
fast_read  in  1  captured on acceptance; 1 = cmd 0Bh plus DUMMY_CYCLES, 0 = cmd 03h.
busy  out  1  high from the cycle after acceptance through the END cycle.
done  out  1  one-cycle pulse in the END cycle.
swap  in  1  toggles disp_sel.
disp_sel  out  1  buffer half currently presented on pix_data.
pix_rst  in  1  rewinds the display pointer to bit 0.
pix_en  in  1  advances the display pointer.
pix_data  out  1  current display bit (combinational from buffer and pointer).
spi_cs  out  1  flash select, active HIGH (board inverts).
spi_sclk  out  1  equals ~clk, continuous.
spi_mosi  out  1  command/address bits, registered on rising clk.
spi_miso  in  1  flash data.

Behaviour:
- Reset (reset=0 at rising clk): spi_cs=0, spi_mosi=0, busy=0, done=0, disp_sel=0, pix_ptr=0, both buffer halves cleared to 0, FSM=IDLE. Reset mid-fetch aborts the fetch immediately; the partially filled half remains cleared.
- FSM states: IDLE -> CMD (8 cycles) -> ADDR (ADDR_WIDTH cycles) -> DUMMY (DUMMY_CYCLES cycles, skipped if fast_read=0 or DUMMY_CYCLES=0) -> DATA (BUFFER_BITS cycles) -> END (1 cycle) -> IDLE.
- Acceptance in cycle 0 (req=1, busy=0, FSM in IDLE):
  - latches req_addr and fast_read;
  - latches fill_sel = ~disp_sel.
- Cycle 1:
  - spi_cs=1, busy=1;
  - spi_mosi = cmd[7].
- Serial timing:
  - Command bits go out in cycles 1..8, MSB first.
  - Address bits go out in cycles 9..8+ADDR_WIDTH, MSB first.
  - spi_mosi=0 during DUMMY, DATA and END.
- Data capture:
  - Let D0 = 9 + ADDR_WIDTH + (fast_read ? DUMMY_CYCLES : 0).
  - spi_miso is sampled on the falling clk edge (rising spi_sclk) in cycles D0..D0+BUFFER_BITS-1.
  - Sample k is written to buffer[fill_sel] bit k on the following rising clk.
  - Stream bit 0 is the MSB of the first flash byte.
- END cycle (cycle D0+BUFFER_BITS):
  - spi_cs=0, done=1, busy stays 1.
  - Next cycle: busy=0, done=0, FSM=IDLE.
  - req is honoured in that next cycle at the earliest; back-to-back fetches therefore have a one-cycle CS-low gap.
- req handling: req while busy=1 (including the END cycle) is ignored, with no queuing.
- swap: toggles disp_sel on any rising clk, whether idle or busy.
  - fill_sel never changes mid-fetch.
  - If a swap makes disp_sel equal fill_sel during a fetch, pix_data shows the half being filled (tearing is permitted; no error).
- Display pointer pix_ptr (width clog2(BUFFER_BITS)+1):
  - pix_rst=1 sets it to 0;
  - else pix_en=1 increments it, saturating at BUFFER_BITS;
  - pix_rst has priority over pix_en.
- pix_data = buffer[disp_sel][pix_ptr] when pix_ptr < BUFFER_BITS, else 0.
- Same-cycle events: swap together with pix_rst both take effect; the new half is read from bit 0 in the next cycle.

Test Plan:
1. Slow read: release reset; req=1 with req_addr=0x000120, fast_read=0 -> mosi carries 0x03 in cycles 1-8 and 0x000120 in cycles 9-32; cs=1 in cycles 1..160; done in cycle 161 (D0=33); busy=0 in cycle 162.
2. Fast read: flash model returns 0xA5 repeated; fast_read=1 -> cmd 0x0B; dummy cycles 33-40; D0=41; done in cycle 169; after swap, pix_data with pix_en held reads 1,0,1,0,0,1,0,1 repeating for 128 bits, then 0.
3. Ping-pong: fill half 1 with 0xFF..., swap, start a fill of half 0 with 0x00... -> pix_data stays 1 throughout the second fetch; after the second swap, pix_data=0.
4. Busy protection: req pulses in cycles 5, 100 and 161 of an active fetch -> no restart; cs stays high until END; a req in cycle 162 is accepted.
5. Reset mid-fetch: reset=0 in cycle 50 -> next cycle cs=0, busy=0, mosi=0, done never pulses, pix_data=0 for all pointer values.
6. Pointer rules: pix_en held 200 cycles -> pointer saturates at 128 and pix_data=0; pix_rst and pix_en together -> pointer=0.

Source files
------------

// File: rtl/vga_spi_line_fetch.sv
// SPI flash line fetcher: issues READ/FAST_READ and streams one line into a ping-pong
// buffer half while the other half is presented bit-serially to the pixel pipeline.
module vga_spi_line_fetch #(
    parameter int BUFFER_BITS  = 128,
    parameter int ADDR_WIDTH   = 24,
    parameter int DUMMY_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  fast_read,
    output logic                  busy,
    output logic                  done,
    input  logic                  swap,
    output logic                  disp_sel,
    input  logic                  pix_rst,
    input  logic                  pix_en,
    output logic                  pix_data,
    output logic                  spi_cs,
    output logic                  spi_sclk,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);
    localparam int IW = $clog2(BUFFER_BITS);
    localparam int PW = IW + 1;
    localparam int SW = 8 + ADDR_WIDTH;
    localparam int M1 = (ADDR_WIDTH > 8) ? ADDR_WIDTH : 8;
    localparam int M2 = (DUMMY_CYCLES > M1) ? DUMMY_CYCLES : M1;
    localparam int MX = (BUFFER_BITS > M2) ? BUFFER_BITS : M2;
    localparam int CW = $clog2(MX) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_END
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          sh_q, sh_d;
    logic                   fast_q, fast_d;
    logic                   fill_q, fill_d;
    logic                   disp_q;
    logic [PW-1:0]          ptr_q, ptr_d;
    logic [BUFFER_BITS-1:0] line_q [2];
    logic                   miso_q;

    // Flash drives on falling SCLK, so capture on rising SCLK (falling clk).
    always_ff @(negedge clk) begin
        miso_q <= spi_miso;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        sh_d    = sh_q;
        fast_d  = fast_q;
        fill_d  = fill_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req) begin
                    state_d = S_CMD;
                    sh_d    = {(fast_read ? 8'h0B : 8'h03), req_addr};
                    fast_d  = fast_read;
                    fill_d  = ~disp_q;
                end
            end
            S_CMD: begin
                sh_d = {sh_q[SW-2:0], 1'b0};
                if (cnt_q == CW'(7)) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                end
            end
            S_ADDR: begin
                sh_d = {sh_q[SW-2:0], 1'b0};
                if (cnt_q == CW'(ADDR_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = (fast_q && (DUMMY_CYCLES != 0)) ? S_DUMMY : S_DATA;
                end
            end
            S_DUMMY: begin
                if (cnt_q == CW'(DUMMY_CYCLES - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (cnt_q == CW'(BUFFER_BITS - 1)) begin
                    state_d = S_END;
                    cnt_d   = '0;
                end
            end
            S_END: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (pix_rst) begin
            ptr_d = '0;
        end else if (pix_en && (ptr_q < PW'(BUFFER_BITS))) begin
            ptr_d = ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            fast_q    <= 1'b0;
            fill_q    <= 1'b0;
            disp_q    <= 1'b0;
            ptr_q     <= '0;
            line_q[0] <= '0;
            line_q[1] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            fast_q  <= fast_d;
            fill_q  <= fill_d;
            disp_q  <= disp_q ^ swap;
            ptr_q   <= ptr_d;
            if (state_q == S_DATA) begin
                line_q[fill_q][cnt_q[IW-1:0]] <= miso_q;
            end
        end
    end

    // The shift register empties to zero after the address, so MOSI idles low.
    assign spi_mosi = sh_q[SW-1];
    assign spi_sclk = ~clk;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_END);
    assign spi_cs   = busy && !done;
    assign disp_sel = disp_q;
    assign pix_data = (ptr_q < PW'(BUFFER_BITS)) ? line_q[disp_q][ptr_q[IW-1:0]] : 1'b0;

endmodule
